// File: rtl/fir_delay_line.sv
// Circular sample history for the FIR datapath: each accepted sample triggers a
// newest-to-oldest tap sweep to the MAC, plus a registered random-access read port.
module fir_delay_line #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_muestreo,
    input  logic             reset_n,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [WIDTH-1:0] tap_data,
    output logic [AW-1:0]    tap_idx,
    output logic             tap_valid,
    input  logic             tap_ready,
    output logic             tap_last,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic [AW:0]      fill_count
);

    typedef enum logic {IDLE, SWEEP} state_t;

    localparam int            LAST    = DEPTH - 1;
    localparam logic [AW:0]   DEPTH_W = DEPTH[AW:0];
    localparam logic [AW:0]   LAST_W  = LAST[AW:0];
    localparam logic [AW-1:0] LAST_K  = LAST[AW-1:0];

    state_t           state;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    k;
    logic [AW:0]      fill;
    logic             accept;

    assign accept = (state == IDLE) && din_valid && !clear;

    // Tap idx lives at (wr_ptr - 1 - idx) mod DEPTH; the extra bit keeps the
    // wrap correct for non-power-of-two depths, and unfilled taps read as zero.
    function automatic logic [WIDTH-1:0] tap_value(input logic [AW-1:0] idx);
        logic [AW:0] addr;
        addr = {1'b0, wr_ptr} + LAST_W - {1'b0, idx};
        if (addr >= DEPTH_W) begin
            addr = addr - DEPTH_W;
        end
        tap_value = '0;
        if (({1'b0, idx} < fill) && (addr < DEPTH_W)) begin
            tap_value = mem[addr[AW-1:0]];
        end
    endfunction

    always_ff @(posedge clk_muestreo or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            wr_ptr <= '0;
            fill   <= '0;
            k      <= '0;
        end else if (clear) begin
            state  <= IDLE;
            wr_ptr <= '0;
            fill   <= '0;
            k      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (din_valid) begin
                        wr_ptr <= (wr_ptr == LAST_K) ? '0 : wr_ptr + 1'b1;
                        fill   <= (fill == DEPTH_W) ? fill : fill + 1'b1;
                        k      <= '0;
                        state  <= SWEEP;
                    end
                end
                SWEEP: begin
                    if (tap_ready) begin
                        if (k == LAST_K) begin
                            k     <= '0;
                            state <= IDLE;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sample storage is deliberately unreset; fill masks stale contents.
    always_ff @(posedge clk_muestreo) begin
        if (accept) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk_muestreo or negedge reset_n) begin
        if (!reset_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= tap_value(rd_addr);
        end
    end

    always_comb begin
        tap_data = tap_value(k);
    end

    assign din_ready  = (state == IDLE);
    assign tap_valid  = (state == SWEEP);
    assign tap_idx    = k;
    assign tap_last   = (state == SWEEP) && (k == LAST_K);
    assign fill_count = fill;

endmodule

// File: tb/tb_fir_delay_line.sv
// Self-checking bench for fir_delay_line: constant vector tables, hand-written corner
// sequences and randomized sweeps compared against a queue-based history model.
module tb_fir_delay_line;

    localparam int WIDTH   = 20;
    localparam int DEPTH   = 8;
    localparam int AW      = 3;
    localparam int DEPTH_B = 5;

    logic             clk_muestreo = 1'b0;
    logic             reset_n;
    logic             clear;
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic [WIDTH-1:0] tap_data;
    logic [AW-1:0]    tap_idx;
    logic             tap_valid;
    logic             tap_ready;
    logic             tap_last;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic [AW:0]      fill_count;

    logic             b_clear;
    logic [WIDTH-1:0] b_din;
    logic             b_din_valid;
    logic             b_din_ready;
    logic [WIDTH-1:0] b_tap_data;
    logic [2:0]       b_tap_idx;
    logic             b_tap_valid;
    logic             b_tap_ready;
    logic             b_tap_last;
    logic [2:0]       b_rd_addr;
    logic [WIDTH-1:0] b_rd_data;
    logic [3:0]       b_fill_count;

    always #5 clk_muestreo = ~clk_muestreo;

    fir_delay_line #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk_muestreo(clk_muestreo), .reset_n(reset_n), .clear(clear),
        .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .tap_data(tap_data), .tap_idx(tap_idx), .tap_valid(tap_valid),
        .tap_ready(tap_ready), .tap_last(tap_last),
        .rd_addr(rd_addr), .rd_data(rd_data), .fill_count(fill_count)
    );

    fir_delay_line #(.WIDTH(WIDTH), .DEPTH(DEPTH_B)) dut_b (
        .clk_muestreo(clk_muestreo), .reset_n(reset_n), .clear(b_clear),
        .din(b_din), .din_valid(b_din_valid), .din_ready(b_din_ready),
        .tap_data(b_tap_data), .tap_idx(b_tap_idx), .tap_valid(b_tap_valid),
        .tap_ready(b_tap_ready), .tap_last(b_tap_last),
        .rd_addr(b_rd_addr), .rd_data(b_rd_data), .fill_count(b_fill_count)
    );

    typedef struct {
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] expected;
    } rd_vec_t;

    int checks = 0;
    int passes = 0;

    // History model: newest sample at the front, never more than DEPTH entries.
    logic [WIDTH-1:0] hist [$];

    function automatic logic [WIDTH-1:0] model_tap(input int kk);
        if (kk < hist.size()) return hist[kk];
        return '0;
    endfunction

    function automatic void model_push(input logic [WIDTH-1:0] x);
        hist.push_front(x);
        if (hist.size() > DEPTH) void'(hist.pop_back());
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!din_ready && n < 64) begin
            @(negedge clk_muestreo);
            n++;
        end
        check_output("din_ready_wait", 32'(din_ready), 32'd1);
    endtask

    task automatic apply_stimulus(input logic [WIDTH-1:0] sample);
        wait_ready();
        din       = sample;
        din_valid = 1'b1;
        tap_ready = 1'b0;
        @(negedge clk_muestreo);
        din_valid = 1'b0;
        model_push(sample);
        check_output("fill_count_accept", 32'(fill_count), hist.size());
        check_output("tap_valid_accept", 32'(tap_valid), 32'd1);
    endtask

    task automatic run_sweep(input bit random_ready, input bit noisy_din, output int cycles);
        int            kk = 0;
        bit            prev_ok = 1'b0;
        logic [AW-1:0] prev_rd = '0;
        cycles = 0;
        while (kk < DEPTH && cycles < 200) begin
            check_output("sweep_tap_valid", 32'(tap_valid), 32'd1);
            check_output("sweep_din_ready", 32'(din_ready), 32'd0);
            check_output("tap_idx", 32'(tap_idx), kk);
            check_output("tap_data", 32'(tap_data), 32'(model_tap(kk)));
            check_output("tap_last", 32'(tap_last), 32'(kk == DEPTH - 1));
            if (prev_ok) check_output("rd_data_sweep", 32'(rd_data), 32'(model_tap(int'(prev_rd))));
            prev_rd   = AW'($urandom_range(0, DEPTH - 1));
            rd_addr   = prev_rd;
            prev_ok   = 1'b1;
            tap_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (noisy_din) begin
                din_valid = 1'($urandom_range(0, 1));
                din       = WIDTH'($urandom);
            end
            @(negedge clk_muestreo);
            cycles++;
            if (tap_ready) kk++;
        end
        tap_ready = 1'b0;
        din_valid = 1'b0;
        check_output("sweep_complete", kk, DEPTH);
        check_output("sweep_end_valid", 32'(tap_valid), 32'd0);
        check_output("sweep_end_ready", 32'(din_ready), 32'd1);
    endtask

    task automatic do_clear();
        clear     = 1'b1;
        tap_ready = 1'b1;
        @(negedge clk_muestreo);
        clear     = 1'b0;
        tap_ready = 1'b0;
        hist.delete();
        check_output("clear_tap_valid", 32'(tap_valid), 32'd0);
        check_output("clear_din_ready", 32'(din_ready), 32'd1);
        check_output("clear_fill", 32'(fill_count), 32'd0);
    endtask

    task automatic apply_rd_table(input rd_vec_t tab [$]);
        foreach (tab[i]) begin
            rd_addr = tab[i].addr;
            @(negedge clk_muestreo);
            check_output($sformatf("rd_table_addr%0d", tab[i].addr), 32'(rd_data),
                         32'(tab[i].expected));
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rd_vec_t tab_ten [$];
        rd_vec_t tab_eight [$];
        int      cyc;

        for (int i = 0; i < DEPTH; i++) tab_ten.push_back('{AW'(i), WIDTH'(10 - i)});
        tab_eight.push_back('{3'd0, 20'd8});
        tab_eight.push_back('{3'd7, 20'd1});
        tab_eight.push_back('{3'd3, 20'd5});

        reset_n = 1'b0; clear = 1'b0; din = '0; din_valid = 1'b0; tap_ready = 1'b0; rd_addr = '0;
        b_clear = 1'b0; b_din = '0; b_din_valid = 1'b0; b_tap_ready = 1'b0; b_rd_addr = '0;

        @(negedge clk_muestreo);
        check_output("reset_din_ready", 32'(din_ready), 32'd1);
        check_output("reset_tap_valid", 32'(tap_valid), 32'd0);
        check_output("reset_tap_last", 32'(tap_last), 32'd0);
        check_output("reset_tap_idx", 32'(tap_idx), 32'd0);
        check_output("reset_tap_data", 32'(tap_data), 32'd0);
        check_output("reset_fill", 32'(fill_count), 32'd0);
        check_output("reset_rd_data", 32'(rd_data), 32'd0);
        reset_n = 1'b1;
        rd_addr = 3'd2;
        @(negedge clk_muestreo);
        check_output("rd_before_write", 32'(rd_data), 32'd0);

        $display("[TB] single sample sweep");
        apply_stimulus(20'h00001);
        run_sweep(1'b0, 1'b0, cyc);
        check_output("sweep_length", cyc, DEPTH);

        $display("[TB] ten samples, wrap and saturation");
        for (int i = 2; i <= 10; i++) begin
            apply_stimulus(WIDTH'(i));
            run_sweep(1'b0, 1'b0, cyc);
        end
        check_output("fill_saturated", 32'(fill_count), 32'd8);
        apply_rd_table(tab_ten);

        $display("[TB] backpressure with ignored din during sweep");
        do_clear();
        for (int i = 1; i <= 8; i++) begin
            apply_stimulus(WIDTH'(i));
            run_sweep(1'b1, 1'b1, cyc);
        end
        apply_rd_table(tab_eight);

        $display("[TB] clear mid-sweep");
        apply_stimulus(20'h5A5A5);
        tap_ready = 1'b1;
        repeat (3) @(negedge clk_muestreo);
        check_output("clear_at_k3_idx", 32'(tap_idx), 32'd3);
        do_clear();
        apply_stimulus(20'hFFFFF);
        run_sweep(1'b0, 1'b0, cyc);

        $display("[TB] randomized sweeps");
        for (int i = 0; i < 30; i++) begin
            apply_stimulus(WIDTH'($urandom));
            run_sweep(1'b1, 1'b1, cyc);
        end

        $display("[TB] async reset mid-sweep");
        apply_stimulus(20'h0ABCD);
        tap_ready = 1'b1;
        repeat (2) @(negedge clk_muestreo);
        #2 reset_n = 1'b0;
        #1;
        check_output("async_tap_valid", 32'(tap_valid), 32'd0);
        check_output("async_din_ready", 32'(din_ready), 32'd1);
        check_output("async_fill", 32'(fill_count), 32'd0);
        tap_ready = 1'b0;
        @(negedge clk_muestreo);
        reset_n = 1'b1;
        hist.delete();
        apply_stimulus(20'h12345);
        run_sweep(1'b0, 1'b0, cyc);

        $display("[TB] DEPTH=5 instance");
        b_tap_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            int n = 0;
            while (!b_din_ready && n < 64) begin
                @(negedge clk_muestreo);
                n++;
            end
            b_din       = WIDTH'(i);
            b_din_valid = 1'b1;
            @(negedge clk_muestreo);
            b_din_valid = 1'b0;
            for (int kk = 0; kk < DEPTH_B; kk++) begin
                if (i == 10) begin
                    check_output("b_tap_idx", 32'(b_tap_idx), kk);
                    check_output("b_tap_data", 32'(b_tap_data), 10 - kk);
                    check_output("b_tap_last", 32'(b_tap_last), 32'(kk == DEPTH_B - 1));
                end
                @(negedge clk_muestreo);
            end
            check_output("b_sweep_end", 32'(b_tap_valid), 32'd0);
        end
        b_tap_ready = 1'b0;
        check_output("b_fill", 32'(b_fill_count), 32'd5);
        b_rd_addr = 3'd6;
        @(negedge clk_muestreo);
        check_output("b_rd_out_of_range", 32'(b_rd_data), 32'd0);
        b_rd_addr = 3'd0;
        @(negedge clk_muestreo);
        check_output("b_rd_newest", 32'(b_rd_data), 32'd10);
        b_rd_addr = 3'd4;
        @(negedge clk_muestreo);
        check_output("b_rd_oldest", 32'(b_rd_data), 32'd6);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
